// File: rtl/fads_pkg.sv
// Shared definitions for the FADS sorter: register offsets, FSM state encodings
// and configuration reset defaults.
package fads_pkg;

    // Register word offsets, decoded on sys_addr[19:0]
    localparam logic [19:0] OffCtrl     = 20'h00000;
    localparam logic [19:0] OffMinW     = 20'h00004;
    localparam logic [19:0] OffMaxW     = 20'h00008;
    localparam logic [19:0] OffDelay    = 20'h0000C;
    localparam logic [19:0] OffPulseLen = 20'h00010;
    localparam logic [19:0] OffDropCnt  = 20'h00014;
    localparam logic [19:0] OffSortCnt  = 20'h00018;
    localparam logic [19:0] OffMissCnt  = 20'h0001C;
    localparam logic [19:0] OffThrBase  = 20'h00020;

    // Configuration reset defaults (MAX_W resets to all-ones of its width)
    localparam int unsigned DefMinW     = 1;
    localparam int unsigned DefPulseLen = 1;
    localparam int unsigned DefLoThr    = 15;
    localparam int unsigned DefHiThr    = 255;

    typedef enum logic {
        DIdle,
        DDrop
    } det_state_e;

    typedef enum logic [1:0] {
        SIdle,
        SDelay,
        SPulse
    } sort_state_e;

    // Lane n thresholds sit in an 8-byte stride: LO at +0, HI at +4
    function automatic logic [19:0] lo_thr_addr(input int unsigned n);
        return OffThrBase + 20'(8 * n);
    endfunction

    function automatic logic [19:0] hi_thr_addr(input int unsigned n);
        return OffThrBase + 20'(8 * n) + 20'h4;
    endfunction

endpackage

// File: rtl/red_pitaya_fads_sorter_if.sv
// System-bus interface of the FADS sorter.
//  master: drives address, write data, byte select and strobes.
//  slave : returns read data, error and acknowledge.
interface red_pitaya_fads_sorter_if;

    logic [31:0] sys_addr;
    logic [31:0] sys_wdata;
    logic [3:0]  sys_sel;
    logic        sys_wen;
    logic        sys_ren;
    logic [31:0] sys_rdata;
    logic        sys_err;
    logic        sys_ack;

    modport master (
        output sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        input  sys_rdata, sys_err, sys_ack
    );

    modport slave (
        input  sys_addr, sys_wdata, sys_sel, sys_wen, sys_ren,
        output sys_rdata, sys_err, sys_ack
    );

endinterface

// File: rtl/red_pitaya_fads_peak.sv
// Per-lane signed running maximum.
//  adc_clk_i/adc_rstn_i : clock, async active-low reset
//  load_i               : start a new droplet, peak takes dat_i
//  upd_i                : fold dat_i into the running max
//  dat_i                : registered signed sample
//  peak_o               : current peak
module red_pitaya_fads_peak #(
    parameter int unsigned DW = 14
) (
    input  logic                 adc_clk_i,
    input  logic                 adc_rstn_i,
    input  logic                 load_i,
    input  logic                 upd_i,
    input  logic signed [DW-1:0] dat_i,
    output logic signed [DW-1:0] peak_o
);

    logic signed [DW-1:0] peak_q;

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            peak_q <= '0;
        end else if (load_i) begin
            peak_q <= dat_i;
        end else if (upd_i && (dat_i > peak_q)) begin
            peak_q <= dat_i;
        end
    end

    assign peak_o = peak_q;

endmodule

// File: rtl/red_pitaya_fads_sorter.sv
// Multi-channel droplet classifier and sort-pulse generator.
//  adc_clk_i   : ADC clock, single domain
//  adc_rstn_i  : async active-low reset
//  adc_dat_i   : packed signed samples, lane n = [n*DW +: DW]; lane 0 detects droplets
//  sort_trig_o : fixed-length sort pulse to the ASG trigger
//  busy_o      : sort FSM not idle
//  bus         : system bus slave (config, thresholds, statistics)
module red_pitaya_fads_sorter
    import fads_pkg::*;
#(
    parameter int unsigned DW     = 14,
    parameter int unsigned CH_NUM = 2,
    parameter int unsigned CW     = 24,
    parameter int unsigned NW     = 32
) (
    input  logic                   adc_clk_i,
    input  logic                   adc_rstn_i,
    input  logic [CH_NUM*DW-1:0]   adc_dat_i,
    output logic                   sort_trig_o,
    output logic                   busy_o,
    red_pitaya_fads_sorter_if.slave bus
);

    // ---------------------------------------------------------------- config
    logic                 enable_q;
    logic [CW-1:0]        min_w_q, max_w_q, delay_q, pulse_len_q;
    logic signed [DW-1:0] lo_thr_q [CH_NUM];
    logic signed [DW-1:0] hi_thr_q [CH_NUM];

    logic [NW-1:0] drop_cnt_q, sort_cnt_q, miss_cnt_q;

    logic [19:0] addr;
    logic [31:0] rd_val;
    logic        clr_stats;

    assign addr      = bus.sys_addr[19:0];
    assign clr_stats = bus.sys_wen && (addr == OffCtrl) && bus.sys_wdata[1];
    assign bus.sys_err = 1'b0;

    logic unused_bus;
    assign unused_bus = ^{bus.sys_sel, bus.sys_addr[31:20], bus.sys_wdata};

    always_comb begin
        rd_val = '0;
        case (addr)
            OffCtrl:     rd_val = {31'b0, enable_q};
            OffMinW:     rd_val = 32'(min_w_q);
            OffMaxW:     rd_val = 32'(max_w_q);
            OffDelay:    rd_val = 32'(delay_q);
            OffPulseLen: rd_val = 32'(pulse_len_q);
            OffDropCnt:  rd_val = 32'(drop_cnt_q);
            OffSortCnt:  rd_val = 32'(sort_cnt_q);
            OffMissCnt:  rd_val = 32'(miss_cnt_q);
            default:     rd_val = '0;
        endcase
        for (int unsigned n = 0; n < CH_NUM; n++) begin
            if (addr == lo_thr_addr(n)) rd_val = 32'(lo_thr_q[n]);
            if (addr == hi_thr_addr(n)) rd_val = 32'(hi_thr_q[n]);
        end
    end

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            bus.sys_ack   <= 1'b0;
            bus.sys_rdata <= '0;
            enable_q      <= 1'b0;
            min_w_q       <= CW'(DefMinW);
            max_w_q       <= '1;
            delay_q       <= '0;
            pulse_len_q   <= CW'(DefPulseLen);
            for (int unsigned n = 0; n < CH_NUM; n++) begin
                lo_thr_q[n] <= DW'(DefLoThr);
                hi_thr_q[n] <= DW'(DefHiThr);
            end
        end else begin
            bus.sys_ack <= bus.sys_wen | bus.sys_ren;
            if (bus.sys_ren) bus.sys_rdata <= rd_val;
            if (bus.sys_wen) begin
                case (addr)
                    OffCtrl:     enable_q    <= bus.sys_wdata[0];
                    OffMinW:     min_w_q     <= bus.sys_wdata[CW-1:0];
                    OffMaxW:     max_w_q     <= bus.sys_wdata[CW-1:0];
                    OffDelay:    delay_q     <= bus.sys_wdata[CW-1:0];
                    OffPulseLen: pulse_len_q <= bus.sys_wdata[CW-1:0];
                    default:     ;
                endcase
                for (int unsigned n = 0; n < CH_NUM; n++) begin
                    if (addr == lo_thr_addr(n)) lo_thr_q[n] <= bus.sys_wdata[DW-1:0];
                    if (addr == hi_thr_addr(n)) hi_thr_q[n] <= bus.sys_wdata[DW-1:0];
                end
            end
        end
    end

    // ----------------------------------------------------------- input stage
    logic signed [DW-1:0] s_q [CH_NUM];

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            for (int unsigned n = 0; n < CH_NUM; n++) s_q[n] <= '0;
        end else begin
            for (int unsigned n = 0; n < CH_NUM; n++) s_q[n] <= adc_dat_i[n*DW +: DW];
        end
    end

    // -------------------------------------------------------------- detector
    det_state_e           d_state_q;
    logic [CW-1:0]        width_q;
    logic signed [DW-1:0] peak [CH_NUM];
    logic                 above, drop_start, drop_end, peak_upd, lanes_ok, accept_end;

    assign above      = s_q[0] > lo_thr_q[0];
    assign drop_start = enable_q && (d_state_q == DIdle) && above;
    assign peak_upd   = enable_q && (d_state_q == DDrop) && above;
    assign drop_end   = enable_q && (d_state_q == DDrop) && !above;

    for (genvar g = 0; g < CH_NUM; g++) begin : g_lane
        red_pitaya_fads_peak #(
            .DW(DW)
        ) u_peak (
            .adc_clk_i  (adc_clk_i),
            .adc_rstn_i (adc_rstn_i),
            .load_i     (drop_start),
            .upd_i      (peak_upd),
            .dat_i      (s_q[g]),
            .peak_o     (peak[g])
        );
    end

    always_comb begin
        lanes_ok = 1'b1;
        for (int unsigned n = 0; n < CH_NUM; n++) begin
            if (!((peak[n] > lo_thr_q[n]) && (peak[n] < hi_thr_q[n]))) lanes_ok = 1'b0;
        end
    end

    assign accept_end = drop_end && lanes_ok && (width_q >= min_w_q) && (width_q <= max_w_q);

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            d_state_q <= DIdle;
            width_q   <= '0;
        end else if (!enable_q) begin
            d_state_q <= DIdle;
        end else begin
            case (d_state_q)
                DIdle: begin
                    if (above) begin
                        d_state_q <= DDrop;
                        width_q   <= CW'(1);
                    end
                end
                DDrop: begin
                    if (!above) begin
                        d_state_q <= DIdle;
                    end else if (width_q != '1) begin
                        width_q <= width_q + CW'(1);
                    end
                end
                default: d_state_q <= DIdle;
            endcase
        end
    end

    // -------------------------------------------------------------- sort FSM
    sort_state_e   s_state_q;
    logic [CW-1:0] dly_cnt_q, pls_cnt_q;
    logic          trig_q;
    logic          sort_start, sort_miss, pulse_entry;

    assign sort_start  = accept_end && (s_state_q == SIdle);
    assign sort_miss   = accept_end && (s_state_q != SIdle);
    assign pulse_entry = enable_q && (s_state_q == SDelay) && (dly_cnt_q == '0);

    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            s_state_q <= SIdle;
            dly_cnt_q <= '0;
            pls_cnt_q <= '0;
            trig_q    <= 1'b0;
        end else if (!enable_q) begin
            s_state_q <= SIdle;
            trig_q    <= 1'b0;
        end else begin
            case (s_state_q)
                SIdle: begin
                    if (accept_end) begin
                        s_state_q <= SDelay;
                        dly_cnt_q <= delay_q;
                    end
                end
                SDelay: begin
                    if (dly_cnt_q == '0) begin
                        s_state_q <= SPulse;
                        trig_q    <= 1'b1;
                        // Remaining cycles after the first; a length of 0 acts as 1
                        pls_cnt_q <= (pulse_len_q == '0) ? '0 : pulse_len_q - CW'(1);
                    end else begin
                        dly_cnt_q <= dly_cnt_q - CW'(1);
                    end
                end
                SPulse: begin
                    if (pls_cnt_q == '0) begin
                        s_state_q <= SIdle;
                        trig_q    <= 1'b0;
                    end else begin
                        pls_cnt_q <= pls_cnt_q - CW'(1);
                    end
                end
                default: begin
                    s_state_q <= SIdle;
                    trig_q    <= 1'b0;
                end
            endcase
        end
    end

    assign sort_trig_o = trig_q;
    assign busy_o      = (s_state_q != SIdle);

    // ------------------------------------------------------------ statistics
    // Saturating; a clear in the same cycle as an increment wins.
    always_ff @(posedge adc_clk_i or negedge adc_rstn_i) begin
        if (!adc_rstn_i) begin
            drop_cnt_q <= '0;
            sort_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else if (clr_stats) begin
            drop_cnt_q <= '0;
            sort_cnt_q <= '0;
            miss_cnt_q <= '0;
        end else begin
            if (drop_end && (drop_cnt_q != '1))    drop_cnt_q <= drop_cnt_q + NW'(1);
            if (pulse_entry && (sort_cnt_q != '1)) sort_cnt_q <= sort_cnt_q + NW'(1);
            if (sort_miss && (miss_cnt_q != '1))   miss_cnt_q <= miss_cnt_q + NW'(1);
        end
    end

    logic unused_start;
    assign unused_start = sort_start;

endmodule

// File: tb/tb_red_pitaya_fads_sorter.sv
// Directed self-checking bench for red_pitaya_fads_sorter (DW=14, CH_NUM=2).
module tb_red_pitaya_fads_sorter;

    localparam int unsigned DW = 14;
    localparam int unsigned CH_NUM = 2;

    logic                 clk;
    logic                 rstn;
    logic [CH_NUM*DW-1:0] adc_dat;
    logic                 sort_trig;
    logic                 busy;

    int checks = 0;
    int errors = 0;

    red_pitaya_fads_sorter_if bus_if ();

    red_pitaya_fads_sorter #(
        .DW     (DW),
        .CH_NUM (CH_NUM),
        .CW     (24),
        .NW     (32)
    ) dut (
        .adc_clk_i   (clk),
        .adc_rstn_i  (rstn),
        .adc_dat_i   (adc_dat),
        .sort_trig_o (sort_trig),
        .busy_o      (busy),
        .bus         (bus_if.slave)
    );

    initial clk = 1'b0;
    always #4 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not finish (errors so far %0d)", errors);
        $fatal(1);
    end

    // ---------------------------------------------------------------- helpers
    task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
        @(negedge clk);
        bus_if.sys_addr  = a;
        bus_if.sys_wdata = d;
        bus_if.sys_wen   = 1'b1;
        @(negedge clk);
        bus_if.sys_wen   = 1'b0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic ack);
        @(negedge clk);
        bus_if.sys_addr = a;
        bus_if.sys_ren  = 1'b1;
        @(negedge clk);
        bus_if.sys_ren  = 1'b0;
        d   = bus_if.sys_rdata;
        ack = bus_if.sys_ack;
    endtask

    task automatic set_adc(input int v0, input int v1);
        logic [DW-1:0] l0, l1;
        l0 = DW'(v0);
        l1 = DW'(v1);
        adc_dat = {l1, l0};
    endtask

    // len cycles of (v0, v1), then both lanes return to 0
    task automatic droplet(input int len, input int v0, input int v1);
        for (int i = 0; i < len; i++) begin
            @(negedge clk);
            set_adc(v0, v1);
        end
        @(negedge clk);
        set_adc(0, 0);
    endtask

    // Count cycles with sort_trig high over a window
    task automatic count_pulse(input int cycles, output int highs);
        highs = 0;
        for (int i = 0; i < cycles; i++) begin
            @(negedge clk);
            if (sort_trig) highs++;
        end
    endtask

    // ------------------------------------------------------------------ tests
    task automatic test_reset();
        logic [31:0] d;
        logic        ack;
        logic [31:0] addrs [10];
        logic [31:0] exps  [10];
        addrs = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h2C};
        exps  = '{32'h0, 32'h1, 32'hFFFFFF, 32'h0, 32'h1, 32'h0, 32'h0, 32'h0, 32'd15, 32'd255};
        checks++;
        if (sort_trig !== 1'b0 || busy !== 1'b0 || bus_if.sys_ack !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: trig=%b busy=%b ack=%b, required 0 0 0",
                     sort_trig, busy, bus_if.sys_ack);
        end
        for (int i = 0; i < 10; i++) begin
            bus_read(addrs[i], d, ack);
            checks++;
            if (d !== exps[i]) begin
                errors++;
                $display("FAIL reset_reg_%0h: got %0h, required %0h", addrs[i], d, exps[i]);
            end
            checks++;
            if (ack !== 1'b1) begin
                errors++;
                $display("FAIL reset_ack_%0h: got %b, required 1", addrs[i], ack);
            end
        end
        @(negedge clk);
        checks++;
        if (bus_if.sys_ack !== 1'b0) begin
            errors++;
            $display("FAIL ack_drop: got %b, required 0", bus_if.sys_ack);
        end
        bus_read(32'h100, d, ack);
        checks++;
        if (d !== 32'h0 || ack !== 1'b1) begin
            errors++;
            $display("FAIL unmapped_read: got %0h ack %b, required 0 ack 1", d, ack);
        end
        // 14-bit all-ones is -1, read back sign-extended
        bus_write(32'h28, 32'h3FFF);
        bus_read(32'h28, d, ack);
        checks++;
        if (d !== 32'hFFFFFFFF) begin
            errors++;
            $display("FAIL sign_extend: got %0h, required ffffffff", d);
        end
        bus_write(32'h28, 32'd15);
    endtask

    task automatic test_main();
        logic [31:0] d;
        logic        ack;
        int          t, m, h;
        bus_write(32'h0C, 32'd5);
        bus_write(32'h10, 32'd3);
        bus_write(32'h00, 32'h1);
        droplet(10, 100, 50);
        t = 0;
        while (!busy && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL main_busy: busy never rose, required 1");
        end
        // busy rises on the accept edge; trigger follows DELAY+1 edges later
        m = 0;
        while (!sort_trig && m < 50) begin
            @(negedge clk);
            m++;
        end
        checks++;
        if (m !== 6) begin
            errors++;
            $display("FAIL main_latency: got %0d, required 6", m);
        end
        h = 0;
        while (sort_trig && h < 50) begin
            h++;
            @(negedge clk);
        end
        checks++;
        if (h !== 3) begin
            errors++;
            $display("FAIL main_pulse_len: got %0d, required 3", h);
        end
        bus_read(32'h14, d, ack);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL main_drop_cnt: got %0d, required 1", d);
        end
        bus_read(32'h18, d, ack);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL main_sort_cnt: got %0d, required 1", d);
        end
    endtask

    task automatic test_width();
        logic [31:0] d;
        logic        ack;
        int          highs;
        int          lens [4];
        int          expp [4];
        lens = '{4, 5, 8, 9};
        expp = '{0, 1, 1, 0};
        bus_write(32'h00, 32'h3);
        bus_write(32'h04, 32'd5);
        bus_write(32'h08, 32'd8);
        bus_write(32'h0C, 32'd0);
        bus_write(32'h10, 32'd1);
        for (int i = 0; i < 4; i++) begin
            droplet(lens[i], 100, 50);
            count_pulse(10, highs);
            checks++;
            if (highs !== expp[i]) begin
                errors++;
                $display("FAIL width_%0d: got %0d pulse cycles, required %0d",
                         lens[i], highs, expp[i]);
            end
        end
        bus_read(32'h14, d, ack);
        checks++;
        if (d !== 32'd4) begin
            errors++;
            $display("FAIL width_drop_cnt: got %0d, required 4", d);
        end
        bus_read(32'h18, d, ack);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL width_sort_cnt: got %0d, required 2", d);
        end
    endtask

    task automatic test_peak();
        logic [31:0] d;
        logic        ack;
        int          highs;
        int          v1s  [4];
        int          expp [4];
        v1s  = '{300, 15, 254, 16};
        expp = '{0, 0, 1, 1};
        bus_write(32'h00, 32'h3);
        bus_write(32'h04, 32'd1);
        bus_write(32'h08, 32'hFFFFFF);
        for (int i = 0; i < 4; i++) begin
            droplet(6, 100, v1s[i]);
            count_pulse(10, highs);
            checks++;
            if (highs !== expp[i]) begin
                errors++;
                $display("FAIL peak_lane1_%0d: got %0d pulse cycles, required %0d",
                         v1s[i], highs, expp[i]);
            end
        end
        bus_read(32'h18, d, ack);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL peak_sort_cnt: got %0d, required 2", d);
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] d;
        logic        ack;
        int          highs;
        bus_write(32'h00, 32'h3);
        bus_write(32'h0C, 32'd100);
        bus_write(32'h10, 32'd2);
        droplet(5, 100, 50);
        repeat (5) @(negedge clk);
        droplet(5, 100, 50);
        count_pulse(150, highs);
        checks++;
        if (highs !== 2) begin
            errors++;
            $display("FAIL b2b_pulse: got %0d pulse cycles, required 2", highs);
        end
        bus_read(32'h1C, d, ack);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL b2b_miss_cnt: got %0d, required 1", d);
        end
        bus_read(32'h18, d, ack);
        checks++;
        if (d !== 32'd1) begin
            errors++;
            $display("FAIL b2b_sort_cnt: got %0d, required 1", d);
        end
        bus_read(32'h14, d, ack);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL b2b_drop_cnt: got %0d, required 2", d);
        end
    endtask

    task automatic test_disable_clear();
        logic [31:0] d;
        logic        ack;
        int          t;
        bus_write(32'h0C, 32'd0);
        bus_write(32'h10, 32'd20);
        bus_write(32'h00, 32'h1);
        droplet(5, 100, 50);
        t = 0;
        while (!sort_trig && t < 20) begin
            @(negedge clk);
            t++;
        end
        checks++;
        if (t >= 20) begin
            errors++;
            $display("FAIL dis_trig_rise: trigger never rose, required 1");
        end
        bus_write(32'h00, 32'h0);
        @(negedge clk);
        checks++;
        if (sort_trig !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL dis_trig_drop: trig=%b busy=%b, required 0 0", sort_trig, busy);
        end
        bus_read(32'h18, d, ack);
        checks++;
        if (d !== 32'd2) begin
            errors++;
            $display("FAIL dis_sort_cnt: got %0d, required 2", d);
        end
        bus_write(32'h00, 32'h2);
        for (int i = 0; i < 4; i++) begin
            logic [31:0] a;
            a = 32'h00 + 32'(i == 0 ? 0 : 16 + 4 * i);
            bus_read(a, d, ack);
            checks++;
            if (d !== 32'h0) begin
                errors++;
                $display("FAIL clear_%0h: got %0h, required 0", a, d);
            end
        end
    endtask

    initial begin
        rstn = 1'b0;
        adc_dat = '0;
        bus_if.sys_addr  = '0;
        bus_if.sys_wdata = '0;
        bus_if.sys_sel   = 4'hF;
        bus_if.sys_wen   = 1'b0;
        bus_if.sys_ren   = 1'b0;
        repeat (3) @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);
        test_reset();
        test_main();
        test_width();
        test_peak();
        test_back_to_back();
        test_disable_clear();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
